rrc_pulse_shaper: RTL and testbench

- 16-tap symmetric root-raised-cosine (RRC) FIR pulse-shaping filter for the BPSK transmit path.
- Takes signed 2-bit symbols (+1 = 2'b01, −1 = 2'b11) at the sample clock and produces a signed 16-bit shaped baseband.
- The output feeds the digital up-converter, which multiplies it with the carrier.

---
 rtl/rrc_pulse_shaper.sv | 92 +++++++++
 tb/tb_rrc_pulse_shaper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rrc_pulse_shaper.sv
// 16-tap symmetric root-raised-cosine FIR pulse shaper for the BPSK TX path.
// Signed symbols in, saturated signed baseband out, one sample per clock.
module rrc_pulse_shaper #(
    parameter int INPUT_WIDTH  = 2,
    parameter int OUTPUT_WIDTH = 16,
    parameter int COEFF_WIDTH  = 14,
    parameter int NUM_TAPS     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    output logic [OUTPUT_WIDTH-1:0] data_out
);

    localparam int ACC_W  = INPUT_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
    localparam int HALF   = NUM_TAPS / 2;
    localparam int HI_W   = ACC_W - OUTPUT_WIDTH + 1;

    // First half of the symmetric impulse response; tap k mirrors NUM_TAPS-1-k.
    function automatic logic signed [COEFF_WIDTH-1:0] coeff(input int k);
        case (k)
            0:       return COEFF_WIDTH'(-60);
            1:       return COEFF_WIDTH'(-150);
            2:       return COEFF_WIDTH'(-120);
            3:       return COEFF_WIDTH'(180);
            4:       return COEFF_WIDTH'(820);
            5:       return COEFF_WIDTH'(1900);
            6:       return COEFF_WIDTH'(3200);
            7:       return COEFF_WIDTH'(4096);
            default: return '0;
        endcase
    endfunction

    logic signed [INPUT_WIDTH-1:0]  x_q [NUM_TAPS];
    logic signed [INPUT_WIDTH-1:0]  x_d [NUM_TAPS];
    logic signed [ACC_W-1:0]        acc_d;
    logic signed [ACC_W-1:0]        pair;
    logic signed [ACC_W-1:0]        coef_ext;
    logic        [HI_W-1:0]         hi;
    logic        [OUTPUT_WIDTH-1:0] data_out_q;
    logic        [OUTPUT_WIDTH-1:0] data_out_d;

    // Delay line shifts one tap per clock; newest sample enters at tap 0.
    always_comb begin
        x_d[0] = data_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k-1];
        end
    end

    // Symmetric pairs are pre-added, so only half the taps need a multiply.
    always_comb begin
        acc_d    = '0;
        pair     = '0;
        coef_ext = '0;
        for (int k = 0; k < HALF; k++) begin
            pair     = ACC_W'(x_q[k]) + ACC_W'(x_q[NUM_TAPS-1-k]);
            coef_ext = ACC_W'(coeff(k));
            acc_d    = acc_d + pair * coef_ext;
        end
    end

    // Clamp to the output range: the bits above the output sign bit
    // must all match it, otherwise pin to the extreme of the same sign.
    always_comb begin
        hi         = acc_d[ACC_W-1:OUTPUT_WIDTH-1];
        data_out_d = acc_d[OUTPUT_WIDTH-1:0];
        if ((|hi) && !(&hi)) begin
            if (acc_d[ACC_W-1]) begin
                data_out_d = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
            end else begin
                data_out_d = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            end
        end
    end

    // Delay line and output register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k] <= '0;
            end
            data_out_q <= '0;
        end else begin
            x_q        <= x_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_rrc_pulse_shaper.sv
// Directed self-checking bench for rrc_pulse_shaper.
// Expected values come from hand-written coefficient tables and a convolution.
module tb_rrc_pulse_shaper;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  data_in = 2'b00;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;

    int h [16] = '{-60, -150, -120, 180, 820, 1900, 3200, 4096,
                   4096, 3200, 1900, 820, 180, -120, -150, -60};

    always #5 clk = ~clk;

    rrc_pulse_shaper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_in = 2'b00;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        data_in = 2'b01;
        #1;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: got %h want 0000", data_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (data_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want 0000", i, data_out);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_edge: got %h want 0000", data_out);
        end
        tick();
        checks++;
        if (data_out !== 16'hFFC4) begin
            errors++;
            $display("FAIL reset_second_edge: got %0d want -60", $signed(data_out));
        end
    endtask

    task automatic test_impulse(input logic [1:0] sym, input int sgn, input string nm);
        int e;
        do_reset();
        data_in = sym;
        tick();
        data_in = 2'b00;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL %s_lat: got %0d want 0", nm, $signed(data_out));
        end
        for (int k = 0; k < 19; k++) begin
            tick();
            e = (k < 16) ? sgn * h[k] : 0;
            checks++;
            if (data_out !== 16'(e)) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d want %0d", nm, k, $signed(data_out), e);
            end
        end
    endtask

    task automatic test_step(input logic [1:0] sym, input int mult,
                             input int settle, input string nm);
        int ps;
        int e;
        do_reset();
        data_in = sym;
        tick();
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL %s_lat: got %0d want 0", nm, $signed(data_out));
        end
        ps = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k < 16) ps += h[k];
            e = mult * ps;
            if (e > 32767) e = 32767;
            if (e < -32768) e = -32768;
            checks++;
            if (data_out !== 16'(e)) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d want %0d", nm, k, $signed(data_out), e);
            end
        end
        checks++;
        if (data_out !== 16'(settle)) begin
            errors++;
            $display("FAIL %s_settle: got %0d want %0d", nm, $signed(data_out), settle);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        data_in = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (data_out !== 16'(13962)) begin
            errors++;
            $display("FAIL midstream_value: got %0d want 13962", $signed(data_out));
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL midstream_async: got %0d want 0", $signed(data_out));
        end
        data_in = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if (data_out !== 16'h0000) begin
                errors++;
                $display("FAIL midstream_cleared[%0d]: got %0d want 0", i, $signed(data_out));
            end
        end
    endtask

    task automatic test_random();
        int inp[$];
        int sym;
        int n;
        int e;
        int got;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            sym = ($urandom_range(0, 1) == 1) ? 1 : -1;
            data_in = (sym > 0) ? 2'b01 : 2'b11;
            for (int r = 0; r < 5; r++) begin
                inp.push_back(sym);
                n = inp.size() - 1;
                tick();
                e = 0;
                for (int k = 0; k < 16; k++) begin
                    if (n - 1 - k >= 0) e += h[k] * inp[n-1-k];
                end
                got = $signed(data_out);
                checks++;
                if (data_out !== 16'(e)) begin
                    errors++;
                    $display("FAIL random[%0d]: got %0d want %0d", n, got, e);
                end
                checks++;
                if (got > 21052 || got < -21052) begin
                    errors++;
                    $display("FAIL random_bound[%0d]: got %0d want |x|<=21052", n, got);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse(2'b01, 1, "impulse_pos");
        test_impulse(2'b11, -1, "impulse_neg");
        test_step(2'b01, 1, 19732, "step_pos");
        test_step(2'b11, -1, -19732, "step_neg");
        test_step(2'b10, -2, -32768, "saturate");
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
